hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Parametrised hazard/stall controller for the 5-stage RISC-V Lite pipeline; successor of the single-cycle hazard unit.
//  Decodes load-use, taken-branch/jump redirect and instruction-memory-wait hazards into PC/IF-ID enables, DE/EX bubble muxes and PC-source select.
//  Adds multi-cycle load-use stall and multi-cycle flush via an FSM with a down-counter, plus saturating stall/flush performance counters.
// PARAMETERS
//  REG_AW        5   register-address width
//  FLUSH_CYCLES  1   cycles (>=1) of fetch squash per redirect, including the redirect cycle
//  LU_CYCLES     1   cycles (>=1) of load-use stall
//  CNT_W        16   width of performance counters
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous active-low reset
//  fsm_pcsrc_en   in   1        global fetch enable from the top-level control FSM
//  ex_mem_read    in   1        instruction in EX is a load
//  ex_rd          in   REG_AW   destination register of EX instruction
//  id_rs1/id_rs2  in   REG_AW   source registers of ID instruction
//  id_use_rs1/2   in   1        ID instruction actually reads rs1/rs2
//  mem_jump       in   1        jump in MEM
//  mem_branch     in   1        branch in MEM
//  mem_br_taken   in   1        branch condition true
//  mem_add_to_pc  in   1        target from branch ALU (1) or jump adder (0)
//  imem_ready     in   1        instruction memory returns valid data this cycle
//  clr_cnt        in   1        synchronous clear of performance counters
//  en_pc/en_ifid  out  1        PC / IF-ID register enables
//  ctrl_mux_de    out  1        0 = inject NOP into ID/EX
//  ctrl_mux_ex    out  1        0 = inject NOP into EX/MEM
//  pc_src         out  2        00 next_pc, 01 branch_alu, 10 branch_pc_jump
//  stall_cnt      out  CNT_W    cycles with en_pc=0 while fsm_pcsrc_en=1
//  flush_cnt      out  CNT_W    accepted redirect events
//  state_o        out  2        FSM state (debug)
// BEHAVIOUR
//  redirect = mem_jump | (mem_branch & mem_br_taken); lu_haz = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  Outputs are combinational from state and inputs; state/counters register on clk.
//  States: RUN(00), LU_STALL(01), FLUSH(10); 2'b11 unreachable, recovers to RUN.
//  Priority in RUN and LU_STALL: redirect > lu_haz/LU_STALL > !imem_ready > normal.
//   redirect: en_pc=1, en_ifid=0, de=0, ex=0, pc_src=mem_add_to_pc?01:10; flush_cnt++; FLUSH_CYCLES>1 -> FLUSH, cnt=FLUSH_CYCLES-2, else RUN.
//   lu_haz in RUN: en_pc=0, en_ifid=0, de=0, ex=1 (load proceeds); LU_CYCLES>1 -> LU_STALL, cnt=LU_CYCLES-2, else stay RUN.
//   LU_STALL: same outputs as lu_haz; cnt==0 -> RUN, else cnt--.
//   !imem_ready: en_pc=0, en_ifid=0, de=0, ex=1; state unchanged.
//   normal: all enables/muxes 1, pc_src=00.
//  FLUSH: en_pc=1, en_ifid=0, de=0, ex=0, pc_src=00; redirect/lu_haz ignored (squashed); cnt==0 -> RUN, else cnt--.
//  fsm_pcsrc_en=0: en_pc=en_ifid=0, pc_src=00, de/ex per state; FSM, cnt and counters frozen, flush_cnt not incremented.
//  Counters saturate at all-ones; clr_cnt wins over an increment in the same cycle.
//  Reset (async, rst_n=0): state=RUN, cnt=0, stall_cnt=flush_cnt=0; outputs then follow RUN rules (en_pc=en_ifid=fsm_pcsrc_en, de=ex=1, pc_src=00 when no hazard input).
//  Reset mid-FLUSH/LU_STALL aborts immediately to RUN.
// TESTING
//  ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1, LU_CYCLES=1 -> one cycle en_pc=0, en_ifid=0, de=0, ex=1; stall_cnt=1.
//  same with ex_rd=0 or id_use_rs2=0 -> no stall; all outputs 1.
//  mem_branch=1, mem_br_taken=1, mem_add_to_pc=1, FLUSH_CYCLES=3 -> pc_src=01 one cycle, then 2 FLUSH cycles (en_ifid=0, de=ex=0), then RUN; flush_cnt=1.
//  redirect and lu_haz in the same cycle -> redirect wins, pc_src=10 for jump, no stall cycle.
//  fsm_pcsrc_en=0 during LU_STALL (LU_CYCLES=3) for 4 cycles -> en_pc=0, cnt frozen; after re-enable the remaining stall cycles complete.
//  CNT_W=2, 5 stall cycles -> stall_cnt saturates at 3; clr_cnt=1 -> 0 next cycle; rst_n low mid-FLUSH -> state_o=00 asynchronously.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: decodes load-use, redirect and imem-wait hazards into pipeline enables and muxes.
// Outputs are combinational from state and inputs. fsm_pcsrc_en=0 freezes fetch, state and counters.
module hazard_stall_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int LU_CYCLES    = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fsm_pcsrc_en,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              mem_jump,
    input  logic              mem_branch,
    input  logic              mem_br_taken,
    input  logic              mem_add_to_pc,
    input  logic              imem_ready,
    input  logic              clr_cnt,
    output logic              en_pc,
    output logic              en_ifid,
    output logic              ctrl_mux_de,
    output logic              ctrl_mux_ex,
    output logic [1:0]        pc_src,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        state_o
);

    localparam int MAXC = (FLUSH_CYCLES > LU_CYCLES) ? FLUSH_CYCLES : LU_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] FL_LOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;
    localparam logic [CW-1:0] LU_LOAD = (LU_CYCLES > 1)    ? CW'(LU_CYCLES - 2)    : '0;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic       w_redirect, w_lu_haz, w_redir_acc;
    logic       w_en_pc, w_en_ifid, w_de, w_ex;
    logic [1:0] w_pc_src;

    assign w_redirect = mem_jump | (mem_branch & mem_br_taken);
    assign w_lu_haz   = ex_mem_read && (ex_rd != '0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_pc     = 1'b1;
        w_en_ifid   = 1'b1;
        w_de        = 1'b1;
        w_ex        = 1'b1;
        w_pc_src    = 2'b00;
        w_redir_acc = 1'b0;
        case (r_state)
            RUN, LU_STALL: begin
                if (w_redirect) begin
                    w_en_ifid   = 1'b0;
                    w_de        = 1'b0;
                    w_ex        = 1'b0;
                    w_pc_src    = mem_add_to_pc ? 2'b01 : 2'b10;
                    w_redir_acc = 1'b1;
                    w_cnt_nxt   = FL_LOAD;
                    w_state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (r_state == LU_STALL) begin
                    w_en_pc   = 1'b0;
                    w_en_ifid = 1'b0;
                    w_de      = 1'b0;
                    if (r_cnt == '0) w_state_nxt = RUN;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end else if (w_lu_haz) begin
                    // The load itself keeps moving into EX/MEM; only the consumer is held.
                    w_en_pc   = 1'b0;
                    w_en_ifid = 1'b0;
                    w_de      = 1'b0;
                    if (LU_CYCLES > 1) begin
                        w_state_nxt = LU_STALL;
                        w_cnt_nxt   = LU_LOAD;
                    end
                end else if (!imem_ready) begin
                    w_en_pc   = 1'b0;
                    w_en_ifid = 1'b0;
                    w_de      = 1'b0;
                end
            end
            FLUSH: begin
                w_en_ifid = 1'b0;
                w_de      = 1'b0;
                w_ex      = 1'b0;
                if (r_cnt == '0) w_state_nxt = RUN;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!fsm_pcsrc_en) begin
            w_en_pc   = 1'b0;
            w_en_ifid = 1'b0;
            w_pc_src  = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else if (fsm_pcsrc_en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (fsm_pcsrc_en && !w_en_pc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (fsm_pcsrc_en && w_redir_acc && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign en_pc       = w_en_pc;
    assign en_ifid     = w_en_ifid;
    assign ctrl_mux_de = w_de;
    assign ctrl_mux_ex = w_ex;
    assign pc_src      = w_pc_src;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign state_o     = r_state;

endmodule
